// File: rtl/dice_roller_mux_display.sv
// rtl/dice_roller_mux_display.sv - multi-die roller with LFSR rejection sampler, double-dabble BCD and scanned 7-seg driver
module dice_roller_mux_display #(
  parameter int          NUM_DIGITS = 4,
  parameter int          SCAN_DIV   = 1024,
  parameter int          MAX_DICE   = 4,
  parameter logic [15:0] SEED       = 16'hACE1,
  localparam int         CW         = (MAX_DICE > 1) ? $clog2(MAX_DICE) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  roll,
  input  logic [2:0]            die_sel,
  input  logic [CW-1:0]         dice_cnt,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [8:0]            total,
  output logic                  busy,
  output logic                  done
);

  localparam int RW = CW + 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, DRAW, CONVERT} state_t;

  state_t        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          roll_q;
  logic [2:0]    sel_q, sel_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [8:0]    acc_q, acc_d;
  logic [20:0]   dd_q, dd_d, dd_adj, dd_shift;
  logic [3:0]    cnt_q, cnt_d;
  logic [8:0]    total_q, total_d;
  logic [11:0]   disp_q, disp_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [6:0]    sides, mask, cand;

  logic [SW-1:0]         scan_q, scan_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  scan_last;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h00;
    endcase
  endfunction

  // Galois form of x^16+x^14+x^13+x^11+1, right-shifting
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    sides = 7'd4;
    mask  = 7'd3;
    case (sel_q)
      3'd0: begin sides = 7'd4;   mask = 7'd3;   end
      3'd1: begin sides = 7'd6;   mask = 7'd7;   end
      3'd2: begin sides = 7'd8;   mask = 7'd7;   end
      3'd3: begin sides = 7'd10;  mask = 7'd15;  end
      3'd4: begin sides = 7'd12;  mask = 7'd15;  end
      3'd5: begin sides = 7'd20;  mask = 7'd31;  end
      3'd6: begin sides = 7'd100; mask = 7'd127; end
      3'd7: begin sides = 7'd2;   mask = 7'd1;   end
      default: ;
    endcase
  end

  assign cand = lfsr_q[6:0] & mask;

  // one double-dabble step: correct each BCD nibble, then shift the whole word
  always_comb begin
    dd_adj = dd_q;
    for (int i = 0; i < 3; i++) begin
      if (dd_q[9+4*i +: 4] >= 4'd5) dd_adj[9+4*i +: 4] = dd_q[9+4*i +: 4] + 4'd3;
    end
    dd_shift = dd_adj << 1;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    dd_d    = dd_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    disp_d  = disp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (roll && !roll_q) begin
          sel_d   = die_sel;
          rem_d   = RW'(dice_cnt) + RW'(1);
          acc_d   = 9'd0;
          busy_d  = 1'b1;
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (cand < sides) begin
          acc_d = acc_q + 9'(cand) + 9'd1;
          rem_d = rem_q - RW'(1);
          if (rem_q == RW'(1)) begin
            dd_d    = {12'd0, acc_d};
            cnt_d   = 4'd0;
            state_d = CONVERT;
          end
        end
      end
      CONVERT: begin
        dd_d  = dd_shift;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd8) begin
          total_d = acc_q;
          disp_d  = dd_shift[20:9];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      roll_q  <= 1'b0;
      sel_q   <= 3'd0;
      rem_q   <= '0;
      acc_q   <= 9'd0;
      dd_q    <= 21'd0;
      cnt_q   <= 4'd0;
      total_q <= 9'd0;
      disp_q  <= 12'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      roll_q  <= roll;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      dd_q    <= dd_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      disp_q  <= disp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // an/seg are built from the next index and next display value so they move together
  assign scan_last = (scan_q == SW'(SCAN_DIV - 1));
  assign scan_d    = scan_last ? '0 : scan_q + SW'(1);

  always_comb begin
    idx_d = idx_q;
    if (scan_last) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
  end

  assign an_d = ~(NUM_DIGITS'(1) << idx_d);

  always_comb begin
    seg_d = 7'h00;
    if (idx_d == IW'(0))
      seg_d = seg_code(disp_d[3:0]);
    else if (idx_d == IW'(1)) begin
      if (disp_d[11:4] != 8'd0) seg_d = seg_code(disp_d[7:4]);
    end else if (idx_d == IW'(2)) begin
      if (disp_d[11:8] != 4'd0) seg_d = seg_code(disp_d[11:8]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= '0;
      idx_q  <= '0;
      an_q   <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
      seg_q  <= 7'h3F;
    end else begin
      scan_q <= scan_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign total = total_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_dice_roller_mux_display.sv
// tb/tb_dice_roller_mux_display.sv - randomized roll bench against a per-roll behavioural model
module tb_dice_roller_mux_display;
  localparam int          ND   = 4;
  localparam int          SD   = 4;
  localparam int          MD   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          roll = 1'b0;
  logic [2:0]    die_sel = 3'd0;
  logic [1:0]    dice_cnt = 2'd0;
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic [8:0]    total;
  logic          busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_lfsr;
  int          m_scan, m_total, m_pend, m_left;
  bit          m_busy, m_done, m_roll_prev;
  bit          seen [7];
  logic [3:0]  exp_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  dice_roller_mux_display #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .MAX_DICE(MD), .SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .roll(roll), .die_sel(die_sel), .dice_cnt(dice_cnt),
    .seg(seg), .an(an), .total(total), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic int sides_of(input int ds);
    case (ds)
      0: return 4;
      1: return 6;
      2: return 8;
      3: return 10;
      4: return 12;
      5: return 20;
      6: return 100;
      default: return 2;
    endcase
  endfunction

  function automatic int mask_of(input int s);
    int m = 0;
    while (m < s - 1) m = m * 2 + 1;
    return m;
  endfunction

  function automatic logic [6:0] dig7(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F; 4: return 7'h66;
      5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F; default: return 7'h6F;
    endcase
  endfunction

  function automatic logic [6:0] seg_model(input int k, input int t);
    int h = t / 100;
    int tn = (t / 10) % 10;
    int u = t % 10;
    if (k == 0) return dig7(u);
    if (k == 1) return (h == 0 && tn == 0) ? 7'h00 : dig7(tn);
    if (k == 2) return (h == 0) ? 7'h00 : dig7(h);
    return 7'h00;
  endfunction

  // whole roll resolved at once: draw count and sum from the LFSR stream after the start cycle
  task automatic plan_roll();
    int s, m, n, cyc, sum, c;
    logic [15:0] v;
    s = sides_of(int'(die_sel));
    m = mask_of(s);
    n = int'(dice_cnt) + 1;
    v = m_lfsr;
    cyc = 0;
    sum = 0;
    while (n > 0) begin
      v = lfsr_step(v);
      cyc++;
      c = int'(v[6:0]) & m;
      if (c < s) begin
        sum += c + 1;
        n--;
      end
    end
    m_pend = sum;
    m_left = cyc + 8;
  endtask

  task automatic model_cycle();
    int k;
    logic [ND-1:0] ea;
    if (rst_n !== 1'b1) begin
      m_lfsr = SEED; m_scan = 0; m_total = 0; m_pend = 0; m_left = 0;
      m_busy = 0; m_done = 0; m_roll_prev = 0;
      return;
    end
    k = m_scan / SD;
    ea = ~(ND'(1) << k);
    check("an", an, ea);
    check("seg", seg, seg_model(k, m_total));
    check("total", total, m_total);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    m_done = 0;
    if (m_busy) begin
      if (m_left == 0) begin
        m_busy = 0;
        m_done = 1;
        m_total = m_pend;
      end else m_left--;
    end else if (roll && !m_roll_prev) begin
      plan_roll();
      m_busy = 1;
    end
    m_lfsr = lfsr_step(m_lfsr);
    m_scan = (m_scan + 1) % (SD * ND);
    m_roll_prev = roll;
  endtask

  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit scramble, output bit ok);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (done === 1'b1) begin
        ok = 1;
        break;
      end
      if (scramble) begin
        die_sel = 3'($urandom_range(7));
        dice_cnt = 2'($urandom_range(3));
      end
      tick();
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  task automatic do_roll(input int ds, input int dc, input bit scramble, output int t);
    bit ok;
    die_sel = 3'(ds);
    dice_cnt = 2'(dc);
    roll = 1;
    tick();
    roll = 0;
    check("busy_after_start", busy, 1);
    wait_done(scramble, ok);
    t = int'(total);
    check("busy_low_with_done", busy, 0);
    tick();
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    int t, ds, dc;
    bit ok;
    rst_n = 0;
    repeat (3) tick();
    rst_n = 1;

    for (int c = 0; c < 16; c++) begin
      check("scan_an", an, exp_an[c / 4]);
      check("scan_seg", seg, (c < 4) ? 7'h3F : 7'h00);
      tick();
    end

    do_roll(7, 3, 0, t);
    check("d2_range", (t >= 4 && t <= 8), 1);

    repeat (200) begin
      repeat ($urandom_range(0, 5)) tick();
      do_roll(6, 3, 1, t);
      check("d100_range", (t >= 4 && t <= 400), 1);
    end

    for (int f = 0; f < 7; f++) seen[f] = 0;
    repeat (1500) begin
      do_roll(1, 0, 0, t);
      check("d6_range", (t >= 1 && t <= 6), 1);
      if (t >= 1 && t <= 6) seen[t] = 1;
    end
    for (int f = 1; f <= 6; f++) check("d6_face_seen", seen[f], 1);

    repeat (100) begin
      ds = int'($urandom_range(0, 7));
      dc = int'($urandom_range(0, 3));
      do_roll(ds, dc, 1, t);
      check("rand_range", (t >= dc + 1 && t <= (dc + 1) * sides_of(ds)), 1);
    end

    die_sel = 3'd2;
    dice_cnt = 2'd3;
    roll = 1;
    tick();
    check("hold_busy", busy, 1);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (done === 1'b1) begin
        ok = 1;
        break;
      end
      roll = ~roll;
      tick();
    end
    check("hold_done_seen", ok, 1);
    roll = 0;
    tick();
    check("no_queued_roll", busy, 0);
    roll = 1;
    tick();
    roll = 0;
    check("roll_after_done", busy, 1);
    wait_done(0, ok);
    tick();

    die_sel = 3'd5;
    dice_cnt = 2'd3;
    roll = 1;
    tick();
    roll = 0;
    tick();
    rst_n = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_total", total, 0);
    check("rst_seg", seg, 7'h3F);
    check("rst_an", an, 4'b1110);
    tick();
    rst_n = 1;
    do_roll(5, 3, 0, t);
    check("post_rst_range", (t >= 4 && t <= 80), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
